// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle for the bit-serial adder
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, one full-adder cell, LSB first over WIDTH cycles
module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic          clock,
  input  logic          reset,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             accept, last_bit, s_bit, c_next;

  assign accept   = bus.start && (state_q != RUN);
  assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
  assign s_bit    = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q == RUN);
    bus.done     = (state_q == DONE);
    bus.sum      = sum_q;
    bus.cout     = cout_q;
    bus.overflow = ovf_q;
  end

  // Subtraction is a + ~b + ~cin, so the inversion happens once at load time.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (accept) begin
      a_d   = bus.a;
      b_d   = bus.sub ? ~bus.b : bus.b;
      c_d   = bus.sub ? ~bus.cin : bus.cin;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d   = {1'b0, a_q[WIDTH-1:1]};
      b_d   = {1'b0, b_q[WIDTH-1:1]};
      c_d   = c_next;
      res_d = {s_bit, res_q[WIDTH-1:1]};
      cnt_d = cnt_q + CW'(1);
      if (last_bit) begin
        sum_d  = {s_bit, res_q[WIDTH-1:1]};
        cout_d = c_next;
        ovf_d  = c_q ^ c_next;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      res_q  <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end
endmodule
